// File: rtl/alu_seq_loader.sv
// -----------------------------------------------------------------------------
// alu_seq_loader
//   Sequential MIPS-funct ALU. Operand A, operand B and the opcode are loaded
//   one after another from a shared data bus, each on a rising edge of the
//   (debounced) load button. The block then executes once, registers the
//   result and status flags, and holds them for display until the next EXEC.
//
// Parameters
//   DATA_W  operand/result width (4..32)
//   OP_W    opcode width, taken from the low bits of i_data (OP_W <= DATA_W)
//
// Ports
//   clock       in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   i_data      in   shared operand/opcode bus
//   i_load      in   load button level; only its rising edge acts
//   i_clear     in   synchronous clear back to WAIT_A (beats a load edge)
//   o_result    out  registered ALU result
//   o_zero      out  registered result == 0
//   o_carry     out  ADD carry-out / SUB borrow, 0 for other ops
//   o_overflow  out  signed overflow on ADD/SUB, 0 for other ops
//   o_err       out  unsupported opcode
//   o_valid     out  result/flags belong to the last loaded A/B/OP
//   o_state     out  FSM state for debug LEDs
// -----------------------------------------------------------------------------
module alu_seq_loader #(
    parameter int DATA_W = 8,
    parameter int OP_W   = 6
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_load,
    input  logic              i_clear,
    output logic [DATA_W-1:0] o_result,
    output logic              o_zero,
    output logic              o_carry,
    output logic              o_overflow,
    output logic              o_err,
    output logic              o_valid,
    output logic [2:0]        o_state
);

    localparam int MSB = DATA_W - 1;

    // FSM encoding is visible on o_state, so it is fixed.
    localparam logic [2:0] S_WAIT_A  = 3'd0;
    localparam logic [2:0] S_WAIT_B  = 3'd1;
    localparam logic [2:0] S_WAIT_OP = 3'd2;
    localparam logic [2:0] S_EXEC    = 3'd3;
    localparam logic [2:0] S_SHOW    = 3'd4;

    // MIPS funct codes
    localparam logic [OP_W-1:0] OP_ADD = OP_W'(6'b100000);
    localparam logic [OP_W-1:0] OP_SUB = OP_W'(6'b100010);
    localparam logic [OP_W-1:0] OP_AND = OP_W'(6'b100100);
    localparam logic [OP_W-1:0] OP_OR  = OP_W'(6'b100101);
    localparam logic [OP_W-1:0] OP_XOR = OP_W'(6'b100110);
    localparam logic [OP_W-1:0] OP_NOR = OP_W'(6'b100111);
    localparam logic [OP_W-1:0] OP_SRL = OP_W'(6'b000010);
    localparam logic [OP_W-1:0] OP_SRA = OP_W'(6'b000011);
    localparam logic [OP_W-1:0] OP_SLL = OP_W'(6'b000000);

    // Shift amounts at or beyond this saturate.
    localparam logic [DATA_W-1:0] SHIFT_LIMIT = DATA_W'(DATA_W);

    logic [2:0]        r_state;
    logic              r_load_q;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [OP_W-1:0]   r_op;
    logic [DATA_W-1:0] r_result;
    logic              r_zero;
    logic              r_carry;
    logic              r_overflow;
    logic              r_err;
    logic              r_valid;

    logic              w_load_edge;
    logic [DATA_W:0]   w_add;
    logic [DATA_W:0]   w_sub;
    logic              w_shift_sat;
    logic [DATA_W-1:0] w_result;
    logic              w_carry;
    logic              w_overflow;
    logic              w_err;

    assign w_load_edge = i_load & ~r_load_q;

    // One extra bit holds ADD carry-out; for SUB it is the borrow (A < B).
    assign w_add       = {1'b0, r_a} + {1'b0, r_b};
    assign w_sub       = {1'b0, r_a} - {1'b0, r_b};
    assign w_shift_sat = (r_b >= SHIFT_LIMIT);

    always_comb begin
        w_result   = '0;
        w_carry    = 1'b0;
        w_overflow = 1'b0;
        w_err      = 1'b0;
        case (r_op)
            OP_ADD: begin
                w_result   = w_add[DATA_W-1:0];
                w_carry    = w_add[DATA_W];
                w_overflow = (r_a[MSB] == r_b[MSB]) && (w_add[MSB] != r_a[MSB]);
            end
            OP_SUB: begin
                w_result   = w_sub[DATA_W-1:0];
                w_carry    = w_sub[DATA_W];
                w_overflow = (r_a[MSB] != r_b[MSB]) && (w_sub[MSB] != r_a[MSB]);
            end
            OP_AND: w_result = r_a & r_b;
            OP_OR:  w_result = r_a | r_b;
            OP_XOR: w_result = r_a ^ r_b;
            OP_NOR: w_result = ~(r_a | r_b);
            OP_SRL: w_result = w_shift_sat ? '0 : (r_a >> r_b);
            OP_SRA: w_result = w_shift_sat ? {DATA_W{r_a[MSB]}}
                                           : $unsigned($signed(r_a) >>> r_b);
            OP_SLL: w_result = w_shift_sat ? '0 : (r_a << r_b);
            default: w_err = 1'b1;   // result stays 0, so zero flag reads 1
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_WAIT_A;
            r_load_q   <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= '0;
            r_result   <= '0;
            r_zero     <= 1'b0;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
            r_err      <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            // Edge detector runs in every state, including during clear.
            r_load_q <= i_load;
            if (i_clear) begin
                r_state    <= S_WAIT_A;
                r_a        <= '0;
                r_b        <= '0;
                r_op       <= '0;
                r_result   <= '0;
                r_zero     <= 1'b0;
                r_carry    <= 1'b0;
                r_overflow <= 1'b0;
                r_err      <= 1'b0;
                r_valid    <= 1'b0;
            end else begin
                case (r_state)
                    S_WAIT_A: begin
                        if (w_load_edge) begin
                            r_a     <= i_data;
                            r_state <= S_WAIT_B;
                        end
                    end
                    S_WAIT_B: begin
                        if (w_load_edge) begin
                            r_b     <= i_data;
                            r_state <= S_WAIT_OP;
                        end
                    end
                    S_WAIT_OP: begin
                        if (w_load_edge) begin
                            r_op    <= i_data[OP_W-1:0];
                            r_state <= S_EXEC;
                        end
                    end
                    S_EXEC: begin
                        // Unconditional; any load activity here is ignored.
                        r_result   <= w_result;
                        r_zero     <= (w_result == '0);
                        r_carry    <= w_carry;
                        r_overflow <= w_overflow;
                        r_err      <= w_err;
                        r_valid    <= 1'b1;
                        r_state    <= S_SHOW;
                    end
                    S_SHOW: begin
                        // Starting a new sequence invalidates the display but
                        // leaves the old result/flags visible.
                        if (w_load_edge) begin
                            r_a     <= i_data;
                            r_valid <= 1'b0;
                            r_state <= S_WAIT_B;
                        end
                    end
                    default: r_state <= S_WAIT_A;
                endcase
            end
        end
    end

    assign o_result   = r_result;
    assign o_zero     = r_zero;
    assign o_carry    = r_carry;
    assign o_overflow = r_overflow;
    assign o_err      = r_err;
    assign o_valid    = r_valid;
    assign o_state    = r_state;

endmodule

// File: tb/tb_alu_seq_loader.sv
// -----------------------------------------------------------------------------
// tb_alu_seq_loader
//   Self-checking bench for alu_seq_loader at DATA_W = OP_W = 6. A behavioural
//   model computes the ALU with plain integer arithmetic; a compare process
//   checks every DUT output against it on each falling edge. Directed cases
//   with hand-computed literals pin both the DUT and the model, followed by
//   randomized load sequences.
// -----------------------------------------------------------------------------
module tb_alu_seq_loader;

    localparam int W    = 6;
    localparam int MOD  = 1 << W;
    localparam int HALF = 1 << (W - 1);

    logic         clock;
    logic         reset_n;
    logic [W-1:0] i_data;
    logic         i_load;
    logic         i_clear;
    logic [W-1:0] o_result;
    logic         o_zero;
    logic         o_carry;
    logic         o_overflow;
    logic         o_err;
    logic         o_valid;
    logic [2:0]   o_state;

    int checks = 0;
    int errors = 0;

    alu_seq_loader #(.DATA_W(W), .OP_W(W)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .i_data     (i_data),
        .i_load     (i_load),
        .i_clear    (i_clear),
        .o_result   (o_result),
        .o_zero     (o_zero),
        .o_carry    (o_carry),
        .o_overflow (o_overflow),
        .o_err      (o_err),
        .o_valid    (o_valid),
        .o_state    (o_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- behavioural model ----------------
    // Returns {err, overflow, carry, result}.
    function automatic logic [W+2:0] model_alu(input int a, input int b, input int op);
        int r, sa, sb, s;
        logic c, v, e;
        r = 0; c = 1'b0; v = 1'b0; e = 1'b0;
        sa = (a >= HALF) ? a - MOD : a;
        sb = (b >= HALF) ? b - MOD : b;
        case (op)
            32: begin s = sa + sb; r = (a + b) % MOD; c = (a + b) >= MOD;
                      v = (s > HALF - 1) || (s < -HALF); end
            34: begin s = sa - sb; r = (a - b + MOD) % MOD; c = (a < b);
                      v = (s > HALF - 1) || (s < -HALF); end
            36: r = a & b;
            37: r = a | b;
            38: r = a ^ b;
            39: r = (MOD - 1) - (a | b);
            2:  r = (b >= W) ? 0 : a / (1 << b);
            3:  r = (b >= W) ? ((sa < 0) ? MOD - 1 : 0) : (((sa >>> b) + MOD) % MOD);
            0:  r = (b >= W) ? 0 : (a * (1 << b)) % MOD;
            default: e = 1'b1;
        endcase
        return {e, v, c, r[W-1:0]};
    endfunction

    int   m_state = 0;
    logic m_loadq = 1'b0;
    int   m_a = 0, m_b = 0, m_op = 0;
    int   m_res = 0;
    logic m_zero = 1'b0, m_carry = 1'b0, m_ovf = 1'b0, m_err = 1'b0, m_valid = 1'b0;

    always @(posedge clock or negedge reset_n) begin
        logic [W+2:0] alu;
        logic         ld_edge;
        if (!reset_n) begin
            m_state <= 0; m_loadq <= 1'b0;
            m_a <= 0; m_b <= 0; m_op <= 0; m_res <= 0;
            m_zero <= 1'b0; m_carry <= 1'b0; m_ovf <= 1'b0; m_err <= 1'b0; m_valid <= 1'b0;
        end else begin
            ld_edge = i_load && !m_loadq;
            m_loadq <= i_load;
            alu = model_alu(m_a, m_b, m_op);
            if (i_clear) begin
                m_state <= 0;
                m_a <= 0; m_b <= 0; m_op <= 0; m_res <= 0;
                m_zero <= 1'b0; m_carry <= 1'b0; m_ovf <= 1'b0; m_err <= 1'b0; m_valid <= 1'b0;
            end else if (m_state == 0 && ld_edge) begin
                m_a <= int'(i_data); m_state <= 1;
            end else if (m_state == 1 && ld_edge) begin
                m_b <= int'(i_data); m_state <= 2;
            end else if (m_state == 2 && ld_edge) begin
                m_op <= int'(i_data); m_state <= 3;
            end else if (m_state == 3) begin
                m_res   <= int'(alu[W-1:0]);
                m_zero  <= (alu[W-1:0] == '0);
                m_carry <= alu[W];
                m_ovf   <= alu[W+1];
                m_err   <= alu[W+2];
                m_valid <= 1'b1;
                m_state <= 4;
            end else if (m_state == 4 && ld_edge) begin
                m_a <= int'(i_data); m_valid <= 1'b0; m_state <= 1;
            end
        end
    end

    function automatic logic [W+7:0] model_vec();
        logic [2:0]   st;
        logic [W-1:0] rs;
        st = m_state[2:0];
        rs = m_res[W-1:0];
        return {st, m_valid, m_err, m_ovf, m_carry, m_zero, rs};
    endfunction

    wire [W+7:0] dut_vec = {o_state, o_valid, o_err, o_overflow, o_carry, o_zero, o_result};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison: {state, valid, err, ovf, carry, zero, result}.
    always @(negedge clock) begin
        check("cycle_outputs", 32'(dut_vec), 32'(model_vec()));
    end

    // ---------------- stimulus helpers (called at a falling edge) ----------------
    task automatic do_load(input int val, input int hold);
        i_data = W'(val);
        i_load = 1'b1;
        repeat (hold) @(negedge clock);
        i_load = 1'b0;
        @(negedge clock);
    endtask

    task automatic run_seq(input int a, input int b, input int op);
        do_load(a, 1);
        do_load(b, 1);
        do_load(op, 1);
    endtask

    // Literal expectation: checks the DUT and the model against hand values.
    task automatic lit(input string name, input int a, input int b, input int op,
                       input int res, input logic c, input logic v, input logic e);
        logic [W+7:0] exp;
        run_seq(a, b, op);
        exp = {3'd4, 1'b1, e, v, c, (res == 0), res[W-1:0]};
        check(name, 32'(dut_vec), 32'(exp));
        check({name, "_model"}, 32'(model_vec()), 32'(exp));
        $display("txn %s: A=%0d B=%0d OP=%0d -> result=%0d c=%0b v=%0b err=%0b",
                 name, a, b, op, o_result, o_carry, o_overflow, o_err);
    endtask

    int ops[9] = '{32, 34, 36, 37, 38, 39, 2, 3, 0};

    initial begin
        reset_n = 1'b0; i_data = '0; i_load = 1'b0; i_clear = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_outputs", 32'(dut_vec), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        // Directed cases (DATA_W = 6)
        lit("add_carry",   50, 20, 32,  6, 1'b1, 1'b0, 1'b0);
        lit("add_ovf",     15, 20, 32, 35, 1'b0, 1'b1, 1'b0);
        lit("sub_pos",     20, 15, 34,  5, 1'b0, 1'b0, 1'b0);
        lit("sub_borrow",  15, 20, 34, 59, 1'b1, 1'b0, 1'b0);
        lit("and",         15, 20, 36,  4, 1'b0, 1'b0, 1'b0);
        lit("or",          15, 20, 37, 31, 1'b0, 1'b0, 1'b0);
        lit("xor",         15, 20, 38, 27, 1'b0, 1'b0, 1'b0);
        lit("nor",         15, 20, 39, 32, 1'b0, 1'b0, 1'b0);
        lit("sra_pos",     20,  3,  3,  2, 1'b0, 1'b0, 1'b0);
        lit("sra_neg",     52,  3,  3, 62, 1'b0, 1'b0, 1'b0);
        lit("srl",         15,  3,  2,  1, 1'b0, 1'b0, 1'b0);
        lit("sra_big",     52,  9,  3, 63, 1'b0, 1'b0, 1'b0);
        lit("sll_big",     52,  9,  0,  0, 1'b0, 1'b0, 1'b0);
        lit("unsupported",  7,  9, 63,  0, 1'b0, 1'b0, 1'b1);

        // Held button: clear to WAIT_A, hold load high for 20 cycles.
        i_clear = 1'b1; @(negedge clock); i_clear = 1'b0;
        do_load(13, 20);
        check("held_state", 32'(o_state), 32'd1);
        // Load B, then hold load through EXEC; FSM must still reach SHOW.
        do_load(2, 1);
        do_load(0, 3);
        check("exec_ignore_state", 32'(o_state), 32'd4);
        check("exec_ignore_result", 32'({o_valid, o_result}), 32'({1'b1, 6'd52}));

        // Clear together with a load edge in SHOW.
        i_clear = 1'b1; i_data = 6'd9; i_load = 1'b1;
        @(negedge clock);
        i_clear = 1'b0; i_load = 1'b0;
        @(negedge clock);
        check("clear_load_state", 32'({o_state, o_valid}), 32'd0);

        // Reset pulse in WAIT_OP after a completed transaction.
        run_seq(10, 11, 32);
        do_load(30, 1);
        do_load(31, 1);
        check("pre_reset_state", 32'(o_state), 32'd2);
        #2 reset_n = 1'b0;
        #1 check("reset_immediate", 32'(dut_vec), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (5) @(negedge clock);
        check("post_reset_idle", 32'({o_state, o_valid}), 32'd0);

        // Randomized sequences.
        for (int n = 0; n < 200; n++) begin
            int a, b, op, ha, hb, ho;
            a  = $urandom_range(0, MOD - 1);
            b  = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 8) : $urandom_range(0, MOD - 1);
            op = ($urandom_range(0, 9) == 9) ? $urandom_range(0, MOD - 1) : ops[$urandom_range(0, 8)];
            ha = $urandom_range(1, 3); hb = $urandom_range(1, 3); ho = $urandom_range(1, 3);
            do_load(a, ha);
            if ($urandom_range(0, 19) == 0) begin
                i_clear = 1'b1; @(negedge clock); i_clear = 1'b0;
            end
            do_load(b, hb);
            repeat ($urandom_range(0, 2)) @(negedge clock);
            do_load(op, ho);
            $display("txn %0d: A=%0d B=%0d OP=%0d -> state=%0d valid=%0b result=%0d c=%0b v=%0b err=%0b",
                     n, a, b, op, o_state, o_valid, o_result, o_carry, o_overflow, o_err);
        end

        repeat (2) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
